// File: rtl/myfsm_seq_det_if.sv
// Serial-stream and configuration bundle for myfsm_seq_det.
// master: the stimulus source / configuration side. slave: the detector.
interface myfsm_seq_det_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned FILL_W = $clog2(W + 1);

    // Serial data and control
    logic              i_x;
    logic              i_valid;
    logic              i_clr;

    // Runtime configuration
    logic              i_cfg_we;
    logic [W-1:0]      i_cfg_pat;
    logic [W-1:0]      i_cfg_mask;
    logic              i_cfg_ovl;

    // Detector results
    logic              o_y;
    logic [FILL_W-1:0] o_fill;
    logic [1:0]        o_state;
    logic [CNT_W-1:0]  o_match_cnt;

    modport master (
        output i_x, i_valid, i_clr, i_cfg_we, i_cfg_pat, i_cfg_mask, i_cfg_ovl,
        input  o_y, o_fill, o_state, o_match_cnt
    );

    modport slave (
        input  i_x, i_valid, i_clr, i_cfg_we, i_cfg_pat, i_cfg_mask, i_cfg_ovl,
        output o_y, o_fill, o_state, o_match_cnt
    );
endinterface

// File: rtl/myfsm_seq_det.sv
// Parametrised serial sequence detector with care-mask, overlap select and
// input-valid gating. Default build (W=4, pattern all ones, non-overlap) behaves
// exactly like the legacy 4-bit run detector.
// Optional match counter: define MYFSM_SEQ_DET_MATCH_CNT_EN to enable it;
// otherwise o_match_cnt is tied to zero and no counter flops exist.
module myfsm_seq_det #(
    parameter int unsigned  W       = 4,
    parameter logic [W-1:0] RST_PAT = {W{1'b1}},
    parameter logic         RST_OVL = 1'b0,
    parameter int unsigned  CNT_W   = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    myfsm_seq_det_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(W + 1);

    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StFilling = 2'd1;
    localparam logic [1:0] StArmed   = 2'd2;
    localparam logic [1:0] StHit     = 2'd3;

    localparam logic [FILL_W-1:0] FillFull = FILL_W'(W);
    localparam logic [FILL_W-1:0] FillArm  = FILL_W'(W - 1);

    // Only the W-1 newest bits are kept; the oldest candidate bit is never reused.
    logic [W-2:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q, y_d;
    logic [1:0]        state_q, state_d;
    logic [W-1:0]      pat_q, mask_q;
    logic              ovl_q;

    logic [W-1:0]      cand;
    logic              hit;

    assign cand = {hist_q, bus.i_x};

    // The fill check guarantees every compared bit was really sampled.
    always_comb begin
        hit = (fill_q >= FillArm) && (((cand ^ pat_q) & mask_q) == '0);
    end

    // Next-state for history, fill and match pulse, in priority order.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        if (bus.i_cfg_we || bus.i_clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.i_valid) begin
            hist_d = cand[W-2:0];
            y_d    = hit;
            if (hit) begin
                if (ovl_q) begin
                    fill_d = FillFull;
                end else begin
                    // Non-overlap: the next match needs W fresh bits.
                    fill_d = '0;
                    hist_d = '0;
                end
            end else if (fill_q != FillFull) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Reported state is derived from the next-cycle pulse and fill values.
    always_comb begin
        if (y_d) begin
            state_d = StHit;
        end else if (fill_d == '0) begin
            state_d = StEmpty;
        end else if (fill_d >= FillArm) begin
            state_d = StArmed;
        end else begin
            state_d = StFilling;
        end
    end

    // Datapath registers; reset clears the partial sequence immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
            state_q <= StEmpty;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
            state_q <= state_d;
        end
    end

    // Configuration registers, loaded only by the write strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pat_q  <= RST_PAT;
            mask_q <= '1;
            ovl_q  <= RST_OVL;
        end else if (bus.i_cfg_we) begin
            pat_q  <= bus.i_cfg_pat;
            mask_q <= bus.i_cfg_mask;
            ovl_q  <= bus.i_cfg_ovl;
        end
    end

    assign bus.o_y     = y_q;
    assign bus.o_fill  = fill_q;
    assign bus.o_state = state_q;

`ifdef MYFSM_SEQ_DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count lands on the same edge as the pulse it counts; saturates at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.i_cfg_we || bus.i_clr) begin
            cnt_d = '0;
        end else if (y_d && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Match counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_match_cnt = cnt_q;
`else
    assign bus.o_match_cnt = '0;
`endif

    a_fill_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        fill_q <= FillFull);
    a_hit_state : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        y_q == (state_q == StHit));
endmodule
